// File: rtl/posit_encoder_pipe.sv
// Three-stage pipelined posit encoder: builds the regime-led body, rounds it
// to n-1 magnitude bits with round-to-nearest-even, then packs sign, special
// values and saturation into an n-bit two's-complement posit.
module posit_encoder_pipe #(
  parameter int unsigned N  = 32,
  parameter int unsigned ES = 3,
  parameter int unsigned RS = 6,
  parameter int unsigned FS = N - ES - 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [RS-1:0] in_k,
  input  logic [ES-1:0] in_e,
  input  logic [FS-1:0] in_frac,
  input  logic          in_zero,
  input  logic          in_inf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit
);

  localparam int unsigned BW  = 2 * N;       // body width
  localparam int unsigned MW  = N - 1;       // magnitude width
  localparam int unsigned RW  = RS + 1;      // regime run/length width
  localparam int unsigned PAD = BW - ES - FS;

  typedef struct packed {
    logic sign;
    logic zero;
    logic inf;
    logic sat_max;
    logic sat_min;
  } flags_t;

  logic            advance;

  logic            neg_k;
  logic [RW-1:0]   k_ext;
  logic [RW-1:0]   run;
  logic [RW-1:0]   len;
  logic [BW-1:0]   regime_field;
  logic [BW-1:0]   tail;
  logic [BW-1:0]   body_c;
  flags_t          flags_c;

  logic            s1_valid;
  flags_t          s1_flags;
  logic [BW-1:0]   s1_body;

  logic [MW-1:0]   mag;
  logic            guard;
  logic            sticky;
  logic            round_up;
  logic            carry_c;
  logic [MW-1:0]   mag_rnd;

  logic            s2_valid;
  flags_t          s2_flags;
  logic [MW-1:0]   s2_mag;
  logic            s2_carry;

  logic [MW-1:0]   mag_fix;
  logic [N-1:0]    posit_c;

  // The whole pipeline freezes while the output word is held by downstream.
  assign advance  = ~(out_valid & ~out_ready);
  assign in_ready = advance;

  // Regime run: k+1 ones then a 0, or -k zeros then a 1; exponent and fraction follow.
  always_comb begin
    neg_k        = in_k[RS-1];
    k_ext        = {in_k[RS-1], in_k};
    run          = neg_k ? (RW'(0) - k_ext) : (k_ext + RW'(1));
    len          = run + RW'(1);
    regime_field = neg_k ? ({1'b1, {(BW-1){1'b0}}} >> run) : ~({BW{1'b1}} >> run);
    tail         = {in_e, in_frac, {PAD{1'b0}}} >> len;
    body_c       = regime_field | tail;
    flags_c.sign    = in_sign;
    flags_c.zero    = in_zero;
    flags_c.inf     = in_inf;
    flags_c.sat_max = ~neg_k & (run >= RW'(N - 1));
    flags_c.sat_min = neg_k & (run >= RW'(N - 1));
  end

  // Stage 1 register: left-aligned body plus flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_flags <= '0;
      s1_body  <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_flags <= flags_c;
      s1_body  <= body_c;
    end
  end

  // Round-to-nearest-even on the bits below the kept magnitude.
  always_comb begin
    mag                = s1_body[BW-1 -: MW];
    guard              = s1_body[BW-1-MW];
    sticky             = |s1_body[BW-2-MW:0];
    round_up           = guard & (sticky | mag[0]);
    {carry_c, mag_rnd} = {1'b0, mag} + N'(round_up);
  end

  // Stage 2 register: rounded magnitude with carry-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_flags <= '0;
      s2_mag   <= '0;
      s2_carry <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_flags <= s1_flags;
      s2_mag   <= mag_rnd;
      s2_carry <= carry_c;
    end
  end

  // Pack: NaR, zero, saturate to maxpos/minpos, then apply the sign.
  always_comb begin
    mag_fix = s2_mag;
    posit_c = '0;
    if (s2_flags.inf) begin
      posit_c = {1'b1, {MW{1'b0}}};
    end else if (s2_flags.zero) begin
      posit_c = '0;
    end else begin
      if (s2_flags.sat_max || s2_carry) begin
        mag_fix = '1;
      end else if (s2_flags.sat_min || (s2_mag == '0)) begin
        mag_fix = MW'(1);
      end
      posit_c = s2_flags.sign ? (~{1'b0, mag_fix} + N'(1)) : {1'b0, mag_fix};
    end
  end

  // Output register; the word holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_posit <= '0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_posit <= posit_c;
      end
    end
  end

endmodule

// File: tb/tb_posit_encoder_pipe.sv
// Scoreboard bench for posit_encoder_pipe: directed encodings, rounding,
// saturation, flags, backpressure, mid-flight reset and random traffic.
module tb_posit_encoder_pipe;

  localparam int unsigned N  = 32;
  localparam int unsigned ES = 3;
  localparam int unsigned RS = 6;
  localparam int unsigned FS = N - ES - 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [RS-1:0] in_k;
  logic [ES-1:0] in_e;
  logic [FS-1:0] in_frac;
  logic          in_zero;
  logic          in_inf;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_posit;

  posit_encoder_pipe #(.N(N), .ES(ES), .RS(RS), .FS(FS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_k      (in_k),
    .in_e      (in_e),
    .in_frac   (in_frac),
    .in_zero   (in_zero),
    .in_inf    (in_inf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    int          cyc;
    bit          lat;
  } exp_t;

  typedef struct {
    bit          s;
    int          k;
    int          e;
    int          f;
    bit          z;
    bit          inf;
    logic [31:0] expv;
  } dir_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  bit   prev_stall = 1'b0;
  logic [31:0] prev_val = '0;
  bit   rnd_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference: spell out the bit string, cut at n-1 bits, round half to even.
  function automatic logic [31:0] ref_posit(input bit s, input int k, input int e,
                                            input int f, input bit z, input bit inf);
    bit     q[$];
    longint m;
    bit     g;
    bit     st;
    if (inf) return 32'h8000_0000;
    if (z) return 32'h0;
    if (k >= int'(N) - 2) m = 64'h7FFF_FFFF;
    else if (k <= -(int'(N) - 1)) m = 1;
    else begin
      if (k >= 0) begin
        repeat (k + 1) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        repeat (-k) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int i = int'(ES) - 1; i >= 0; i--) q.push_back(((e >> i) & 1) != 0);
      for (int i = int'(FS) - 1; i >= 0; i--) q.push_back(((f >> i) & 1) != 0);
      while (q.size() < 2 * N) q.push_back(1'b0);
      m = 0;
      for (int i = 0; i < int'(N) - 1; i++) m = m * 2 + longint'(q[i]);
      g  = q[N-1];
      st = 1'b0;
      for (int i = int'(N); i < 2 * int'(N); i++) st = st | q[i];
      if (g && (st || (m % 2 == 1))) m = m + 1;
      if (m > 64'h7FFF_FFFF) m = 64'h7FFF_FFFF;
      if (m == 0) m = 1;
    end
    return s ? 32'(-m) : 32'(m);
  endfunction

  // Present one word, wait (bounded) for in_ready, record the expectation.
  task automatic send(input bit s, input int k, input int e, input int f, input bit z,
                      input bit inf, input logic [31:0] expv, input bit lat);
    int w = 0;
    in_valid = 1'b1;
    in_sign  = s;
    in_k     = RS'(k);
    in_e     = ES'(e);
    in_frac  = FS'(f);
    in_zero  = z;
    in_inf   = inf;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'(1));
    else sb.push_back('{expv, cyc, lat});
    @(negedge clk);
  endtask

  task automatic send_rand(input bit lat);
    bit s;
    int k;
    int e;
    int f;
    bit z;
    bit inf;
    s   = 1'($urandom_range(0, 1));
    k   = int'($urandom_range(0, 63)) - 32;
    e   = int'($urandom_range(0, 7));
    f   = int'($urandom_range(0, (1 << FS) - 1));
    z   = ($urandom_range(0, 15) == 0);
    inf = ($urandom_range(0, 15) == 0);
    send(s, k, e, f, z, inf, ref_posit(s, k, e, f, z, inf), lat);
  endtask

  // Monitor: compare each newly presented word; check hold and in_ready every cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        chk("in_ready", 32'(in_ready), (out_valid && !out_ready) ? 32'(0) : 32'(1));
        if (out_valid) begin
          if (prev_stall) begin
            chk("stall_hold", out_posit, prev_val);
          end else if (sb.size() == 0) begin
            chk("unexpected_output", 32'(out_valid), 32'(0));
          end else begin
            x = sb.pop_front();
            chk("posit", out_posit, x.val);
            if (x.lat) chk("latency", 32'(cyc), 32'(x.cyc + 3));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_val   = out_posit;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dir_t dirs[] = '{
      '{1'b0,   0, 0, 0, 1'b0, 1'b0, 32'h4000_0000},
      '{1'b1,   0, 0, 0, 1'b0, 1'b0, 32'hC000_0000},
      '{1'b0,  -1, 0, 0, 1'b0, 1'b0, 32'h2000_0000},
      '{1'b0,   1, 5, 0, 1'b0, 1'b0, 32'h6A00_0000},
      '{1'b0,  27, 3, 0, 1'b0, 1'b0, 32'h7FFF_FFFA},
      '{1'b0,  27, 2, 0, 1'b0, 1'b0, 32'h7FFF_FFF9},
      '{1'b0,  27, 3, 1, 1'b0, 1'b0, 32'h7FFF_FFFA},
      '{1'b0,  31, 0, 0, 1'b0, 1'b0, 32'h7FFF_FFFF},
      '{1'b0,  30, 0, 0, 1'b0, 1'b0, 32'h7FFF_FFFF},
      '{1'b0, -32, 0, 0, 1'b0, 1'b0, 32'h0000_0001},
      '{1'b1, -32, 0, 0, 1'b0, 1'b0, 32'hFFFF_FFFF},
      '{1'b0, -30, 0, 0, 1'b0, 1'b0, 32'h0000_0001},
      '{1'b0,   5, 7, 123, 1'b1, 1'b0, 32'h0000_0000},
      '{1'b1,   3, 6, 99, 1'b1, 1'b0, 32'h0000_0000},
      '{1'b0,   2, 1, 7, 1'b1, 1'b1, 32'h8000_0000},
      '{1'b1,  -4, 4, 5, 1'b0, 1'b1, 32'h8000_0000}
    };

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_k      = '0;
    in_e      = '0;
    in_frac   = '0;
    in_zero   = 1'b0;
    in_inf    = 1'b0;
    out_ready = 1'b1;

    #12;
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_out_posit", out_posit, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'(1));

    // Directed encodings, one at a time with latency checked.
    foreach (dirs[i]) begin
      send(dirs[i].s, dirs[i].k, dirs[i].e, dirs[i].f, dirs[i].z, dirs[i].inf, dirs[i].expv, 1'b1);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
    end

    // Back-to-back stream: each word exactly 3 cycles after its accept, one per cycle.
    for (int i = 0; i < 8; i++) send_rand(1'b1);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Backpressure: 8 distinct words with a 5-cycle stall mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          int f;
          f = int'($urandom_range(0, (1 << FS) - 1));
          send(i[0], i - 4, i, f, 1'b0, 1'b0, ref_posit(i[0], i - 4, i, f, 1'b0, 1'b0), 1'b0);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (sb.size() != 0) chk("post_release_flow", 32'(out_valid), 32'(1));
        end
      end
    join
    chk("bp_all_drained", 32'(sb.size()), 32'(0));

    // Reset with three words in flight.
    send(1'b0, 2, 1, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    send(1'b1, -3, 2, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    in_valid = 1'b1;
    in_k     = RS'(4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'(0));
    chk("midreset_out_posit", out_posit, 32'h0);
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    send(1'b0, 0, 0, 0, 1'b0, 1'b0, 32'h4000_0000, 1'b1);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);

    // Random traffic with random input gaps and random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
          end
          send_rand(1'b0);
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
